// File: rtl/nvdla_mcif_rd_req_arb.sv
// N-channel MCIF read-request concentrator: round-robin request merge, in-order
// response return through a tag FIFO, per-channel outstanding limits and credit pops.
module nvdla_mcif_rd_req_arb #(
  parameter int NUM_CH      = 3,
  parameter int REQ_W       = 79,
  parameter int RSP_W       = 129,
  parameter int TAG_DEPTH   = 16,
  parameter int CH_OUTS_MAX = 8
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic [NUM_CH-1:0]           ch_rd_req_valid,
  output logic [NUM_CH-1:0]           ch_rd_req_ready,
  input  logic [NUM_CH*REQ_W-1:0]     ch_rd_req_pd,
  output logic                        mc_rd_req_valid,
  input  logic                        mc_rd_req_ready,
  output logic [REQ_W-1:0]            mc_rd_req_pd,
  input  logic                        mc_rd_rsp_valid,
  output logic                        mc_rd_rsp_ready,
  input  logic [RSP_W-1:0]            mc_rd_rsp_pd,
  output logic [NUM_CH-1:0]           ch_rd_rsp_valid,
  input  logic [NUM_CH-1:0]           ch_rd_rsp_ready,
  output logic [RSP_W-1:0]            ch_rd_rsp_pd,
  output logic [NUM_CH-1:0]           ch_cdt_lat_fifo_pop,
  output logic [$clog2(TAG_DEPTH):0]  outs_cnt_total,
  output logic                        rsp_orphan_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int OC_W  = $clog2(CH_OUTS_MAX + 1);

  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             req_valid_q, req_valid_d;
  logic [REQ_W-1:0] req_pd_q, req_pd_d;
  logic [CH_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [CH_W-1:0]  tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [OC_W-1:0]  outs_cnt_q [NUM_CH];
  logic [OC_W-1:0]  outs_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] cdt_pop_q, cdt_pop_d;
  logic             orphan_q, orphan_d;

  logic              full, empty, slot_open;
  logic [NUM_CH-1:0] eligible, grant;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx, cand;
  int unsigned       idx;
  logic [REQ_W-1:0]  pd_sel;
  logic [CH_W-1:0]   head;
  logic              rsp_sel_ready, rsp_hs;

  // Arbitration: search upward from the round-robin pointer with wrap.
  always_comb begin
    full      = (occ_q == CNT_W'(TAG_DEPTH));
    empty     = (occ_q == '0);
    slot_open = !req_valid_q || mc_rd_req_ready;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = ch_rd_req_valid[i] && (outs_cnt_q[i] < OC_W'(CH_OUTS_MAX)) && !full;
    end
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    cand      = '0;
    if (slot_open && !nvdla_core_rst) begin
      for (int unsigned off = 0; off < NUM_CH; off++) begin
        idx = 32'(rr_ptr_q) + off;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        cand = CH_W'(idx);
        if (!grant_vld && eligible[cand]) begin
          grant_vld   = 1'b1;
          grant_idx   = cand;
          grant[cand] = 1'b1;
        end
      end
    end
    pd_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) pd_sel = ch_rd_req_pd[i*REQ_W +: REQ_W];
    end
  end

  // Response routing: the tag FIFO head names the channel owning the next beat.
  always_comb begin
    head            = tag_mem_q[rd_ptr_q];
    ch_rd_rsp_valid = '0;
    rsp_sel_ready   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (head == CH_W'(i)) begin
        ch_rd_rsp_valid[i] = mc_rd_rsp_valid && !empty;
        rsp_sel_ready      = ch_rd_rsp_ready[i];
      end
    end
    mc_rd_rsp_ready = !empty && rsp_sel_ready;
    rsp_hs          = mc_rd_rsp_valid && mc_rd_rsp_ready;
    ch_rd_rsp_pd    = mc_rd_rsp_pd;
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_pd_d    = req_pd_q;
    rr_ptr_d    = rr_ptr_q;
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    outs_cnt_d  = outs_cnt_q;
    cdt_pop_d   = '0;
    orphan_d    = orphan_q || (mc_rd_rsp_valid && empty);
    if (grant_vld) begin
      req_valid_d         = 1'b1;
      req_pd_d            = pd_sel;
      rr_ptr_d            = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end else if (mc_rd_req_ready) begin
      req_valid_d = 1'b0;
    end
    if (rsp_hs) rd_ptr_d = rd_ptr_q + 1'b1;
    if (grant_vld && !rsp_hs) occ_d = occ_q + 1'b1;
    else if (!grant_vld && rsp_hs) occ_d = occ_q - 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i] && !(rsp_hs && head == CH_W'(i))) outs_cnt_d[i] = outs_cnt_q[i] + 1'b1;
      else if (!grant[i] && rsp_hs && head == CH_W'(i)) outs_cnt_d[i] = outs_cnt_q[i] - 1'b1;
      cdt_pop_d[i] = rsp_hs && (head == CH_W'(i));
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      rr_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      req_pd_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cdt_pop_q   <= '0;
      orphan_q    <= 1'b0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) outs_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      req_valid_q <= req_valid_d;
      req_pd_q    <= req_pd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cdt_pop_q   <= cdt_pop_d;
      orphan_q    <= orphan_d;
      tag_mem_q   <= tag_mem_d;
      outs_cnt_q  <= outs_cnt_d;
    end
  end

  assign ch_rd_req_ready     = grant;
  assign mc_rd_req_valid     = req_valid_q;
  assign mc_rd_req_pd        = req_pd_q;
  assign ch_cdt_lat_fifo_pop = cdt_pop_q;
  assign outs_cnt_total      = occ_q;
  assign rsp_orphan_err      = orphan_q;

endmodule

// File: doc/nvdla_mcif_rd_req_arb.md
Name: nvdla_mcif_rd_req_arb

Overview:
- Parametrised N-channel read-request concentrator for a partition that owns several MCIF read clients (e.g. SDP main, SDP-B, SDP-N).
- Round-robin arbitrates per-channel read requests onto one registered MCIF read-request port.
- Tracks issue order in a tag FIFO and routes in-order read responses back to the issuing channel.
- Enforces a per-channel outstanding limit and produces a per-channel latency-FIFO credit-pop pulse.

Parameters:
- NUM_CH, 3, number of client channels (1..8).
- REQ_W, 79, request payload width.
- RSP_W, 129, response payload width.
- TAG_DEPTH, 16, tag FIFO depth = total outstanding requests (power of 2).
- CH_OUTS_MAX, 8, max outstanding requests per channel (≤ TAG_DEPTH).

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- ch_rd_req_valid  in  NUM_CH  per-channel request valid.
- ch_rd_req_ready  out  NUM_CH  per-channel request accept.
- ch_rd_req_pd  in  NUM_CH*REQ_W  packed request payloads; channel i at [i*REQ_W +: REQ_W].
- mc_rd_req_valid  out  1  merged request valid.
- mc_rd_req_ready  in  1  merged request accept.
- mc_rd_req_pd  out  REQ_W  merged request payload.
- mc_rd_rsp_valid  in  1  response valid.
- mc_rd_rsp_ready  out  1  response accept.
- mc_rd_rsp_pd  in  RSP_W  response payload.
- ch_rd_rsp_valid  out  NUM_CH  per-channel response valid, one-hot.
- ch_rd_rsp_ready  in  NUM_CH  per-channel response accept.
- ch_rd_rsp_pd  out  RSP_W  response payload, shared across channels.
- ch_cdt_lat_fifo_pop  out  NUM_CH  one-cycle credit-pop pulse.
- outs_cnt_total  out  clog2(TAG_DEPTH)+1  current number of outstanding requests.
- rsp_orphan_err  out  1  sticky: response arrived with no outstanding request.

Behaviour:
- Reset (async assert, sync release): all outputs 0; round-robin pointer = channel 0; per-channel counters = 0; tag FIFO empty; rsp_orphan_err = 0.
- Eligibility: channel i is eligible when ch_rd_req_valid[i], outs_cnt[i] < CH_OUTS_MAX, and the tag FIFO is not full.
  - A push is blocked on a full FIFO even if a pop occurs in the same cycle.
- Output slot: the output register is open when it is empty or when mc_rd_req_valid & mc_rd_req_ready.
- Grant: when the output slot is open, grant the first eligible channel searching from the pointer upward with wrap.
  - ch_rd_req_ready is combinational and equal to the one-hot grant vector.
  - No grant is issued while the slot is blocked.
- On grant to channel g:
  - mc_rd_req_pd and valid are registered on the next edge, giving 1-cycle latency.
  - g is pushed into the tag FIFO and outs_cnt[g] is incremented.
  - The pointer moves to (g+1) mod NUM_CH.
  - Without a grant, the pointer holds.
- mc_rd_req_valid, once high, holds with a stable pd until mc_rd_req_ready is seen.
- Response routing:
  - h = tag FIFO head.
  - ch_rd_rsp_valid[h] = mc_rd_rsp_valid & !empty.
  - mc_rd_rsp_ready = !empty & ch_rd_rsp_ready[h].
  - Response pd passes through combinationally.
  - Each request returns exactly one response beat, in order.
- On response handshake:
  - The tag FIFO pops and outs_cnt[h] is decremented.
  - ch_cdt_lat_fifo_pop[h] pulses high for 1 cycle on the next clock.
- Same-cycle grant and response on one channel: the count is unchanged; the FIFO pushes and pops together unless full.
- Orphan response: mc_rd_rsp_valid while the FIFO is empty gives ready = 0 and sets rsp_orphan_err, which clears only on reset.
- outs_cnt_total = FIFO occupancy, registered.
- Reset mid-transfer: all in-flight state is discarded; there is no replay.

Test Plan:
1. Round-robin fairness: all 3 channels valid continuously, mc ready = 1 → grants 0,1,2,0,1,2; mc_rd_req_valid first high 1 cycle after the first grant.
2. Backpressure: mc_rd_req_ready = 0 for 5 cycles with channel 1 granted → pd and valid stable, no further grants, pointer held at 2.
3. Per-channel limit: channel 0 only, responses withheld → exactly 8 grants, then ch_rd_req_ready[0] = 0. One response → one more grant; ch_cdt_lat_fifo_pop[0] pulses once.
4. Response routing: issue order 2,0,1, then 3 responses → ch_rd_rsp_valid = 100, 001, 010 in order. ch_rd_rsp_ready[0] = 0 stalls mc_rd_rsp_ready.
5. Tag FIFO full with NUM_CH = 3, CH_OUTS_MAX = 8, TAG_DEPTH = 16: 16 outstanding → no grant even if a channel is under its limit; outs_cnt_total = 16.
6. Orphan and reset: a response with the FIFO empty → rsp_orphan_err = 1 and stays set. Async reset mid-burst → all outputs 0 immediately, pointer back to 0.
